// File: rtl/hight_pkg.sv
// HIGHT round-core package: FSM state codes, round constants, whitening key map
// and the byte-level F0/F1/whitening helpers shared by the datapath.
package hight_pkg;

    localparam int unsigned NROUNDS = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_ROUND = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Whitening key WK_i is master-key byte MK_{wk_mk_idx(i)}: WK0..3 = MK12..15, WK4..7 = MK0..3.
    function automatic int unsigned wk_mk_idx(input int unsigned i);
        return (i < 4) ? i + 12 : i - 4;
    endfunction

    // F0(x) = rol1 ^ rol2 ^ rol7
    function automatic logic [7:0] f0(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[0], x[7:1]};
    endfunction

    // F1(x) = rol3 ^ rol4 ^ rol6
    function automatic logic [7:0] f1(input logic [7:0] x);
        return {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ {x[1:0], x[7:2]};
    endfunction

    // Whitening on lanes 0,2,4,6 with four key bytes; sub selects the inverse (mod-256 subtract).
    function automatic logic [63:0] whiten(input logic [63:0] x, input logic [31:0] k,
                                           input logic sub);
        logic [63:0] y;
        y         = x;
        y[7:0]    = sub ? x[7:0] - k[7:0] : x[7:0] + k[7:0];
        y[23:16]  = x[23:16] ^ k[15:8];
        y[39:32]  = sub ? x[39:32] - k[23:16] : x[39:32] + k[23:16];
        y[55:48]  = x[55:48] ^ k[31:24];
        return y;
    endfunction

endpackage

// File: rtl/hight_round_fn.sv
// HIGHT single round, purely combinational. Encrypt or decrypt (ed), with
// 'last' selecting the unrotated final round (encrypt) / first undo (decrypt).
module hight_round_fn
    import hight_pkg::*;
(
    input  logic [63:0] x,
    input  logic [7:0]  sk0,
    input  logic [7:0]  sk1,
    input  logic [7:0]  sk2,
    input  logic [7:0]  sk3,
    input  logic        ed,
    input  logic        last,
    output logic [63:0] y
);

    logic [7:0] xb [8];
    logic [7:0] yb [8];

    // One round on byte lanes; decrypt recovers the even lanes first, then undoes the odd ones.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            xb[i] = x[8*i +: 8];
        end
        yb = xb;
        if (ed) begin
            if (last) begin
                yb[1] = xb[1] + (f1(xb[0]) ^ sk0);
                yb[3] = xb[3] ^ (f0(xb[2]) + sk1);
                yb[5] = xb[5] + (f1(xb[4]) ^ sk2);
                yb[7] = xb[7] ^ (f0(xb[6]) + sk3);
            end else begin
                yb[0] = xb[7] ^ (f0(xb[6]) + sk3);
                yb[1] = xb[0];
                yb[2] = xb[1] + (f1(xb[0]) ^ sk0);
                yb[3] = xb[2];
                yb[4] = xb[3] ^ (f0(xb[2]) + sk1);
                yb[5] = xb[4];
                yb[6] = xb[5] + (f1(xb[4]) ^ sk2);
                yb[7] = xb[6];
            end
        end else begin
            if (last) begin
                yb[1] = xb[1] - (f1(xb[0]) ^ sk0);
                yb[3] = xb[3] ^ (f0(xb[2]) + sk1);
                yb[5] = xb[5] - (f1(xb[4]) ^ sk2);
                yb[7] = xb[7] ^ (f0(xb[6]) + sk3);
            end else begin
                yb[0] = xb[1];
                yb[2] = xb[3];
                yb[4] = xb[5];
                yb[6] = xb[7];
                yb[7] = xb[0] ^ (f0(xb[7]) + sk3);
                yb[1] = xb[2] - (f1(xb[1]) ^ sk0);
                yb[3] = xb[4] ^ (f0(xb[3]) + sk1);
                yb[5] = xb[6] - (f1(xb[5]) ^ sk2);
            end
        end
        for (int i = 0; i < 8; i++) begin
            y[8*i +: 8] = yb[i];
        end
    end

endmodule

// File: rtl/hight_round_core.sv
// Iterative HIGHT 64-bit block cipher core: one round per clock, encrypt or decrypt.
// Drives the external subkey generator (sk_init/sk_ed) and consumes sk0..sk3.
// Optional build macro HIGHT_CLR_ON_DONE_EN: wipe data, whitening and dout on DONE->IDLE.
module hight_round_core
    import hight_pkg::*;
#(
    parameter int unsigned SK_LAT = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         ed,
    input  logic [63:0]  din,
    input  logic [127:0] mk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  dout,
    output logic         sk_init,
    output logic         sk_ed,
    input  logic [7:0]   sk0,
    input  logic [7:0]   sk1,
    input  logic [7:0]   sk2,
    input  logic [7:0]   sk3,
    output logic         busy
);

    localparam logic [2:0] LAT_M1    = 3'(SK_LAT - 1);
    localparam logic [4:0] LAST_RND  = 5'(NROUNDS - 1);
    localparam bit         SKIP_WAIT = (SK_LAT == 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [63:0] data_q, data_d;
    logic [63:0] wk_q, wk_d;
    logic [63:0] dout_q, dout_d;
    logic        ed_q, ed_d;
    // Holds in_ready low until the first clock after reset release.
    logic        armed_q;

    logic [63:0] wk_in;
    logic [63:0] data_in;
    logic [63:0] round_y;
    logic [63:0] data_out;
    logic        round_last;
    logic        accept;

    // Gather the eight whitening bytes from the master key.
    always_comb begin
        wk_in = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            wk_in[8*i +: 8] = mk[8*wk_mk_idx(i) +: 8];
        end
    end

    // Input transform at accept: WK0..3 forward for encrypt, inverse WK4..7 for decrypt.
    always_comb begin
        data_in = ed ? whiten(din, wk_in[31:0], 1'b0) : whiten(din, wk_in[63:32], 1'b1);
    end

    // Decrypt consumes generator round 31 first, so its unrotated step is at r = 0.
    always_comb begin
        round_last = ed_q ? (rnd_q == LAST_RND) : (rnd_q == 5'd0);
    end

    hight_round_fn u_round (
        .x    (data_q),
        .sk0  (sk0),
        .sk1  (sk1),
        .sk2  (sk2),
        .sk3  (sk3),
        .ed   (ed_q),
        .last (round_last),
        .y    (round_y)
    );

    // Output transform after the final round.
    always_comb begin
        data_out = ed_q ? whiten(round_y, wk_q[63:32], 1'b0) : whiten(round_y, wk_q[31:0], 1'b1);
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        in_ready  = armed_q && (state_q == ST_IDLE);
        accept    = in_valid && in_ready;
        sk_init   = accept;
        sk_ed     = ed_q;
        busy      = (state_q != ST_IDLE);
        out_valid = (state_q == ST_DONE);
        dout      = dout_q;
    end

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        data_d  = data_q;
        wk_d    = wk_q;
        dout_d  = dout_q;
        ed_d    = ed_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ed_d    = ed;
                    wk_d    = wk_in;
                    data_d  = data_in;
                    rnd_d   = 5'd0;
                    cnt_d   = LAT_M1;
                    state_d = SKIP_WAIT ? ST_ROUND : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rnd_d = rnd_q + 5'd1;
                if (rnd_q == LAST_RND) begin
                    data_d  = data_out;
                    dout_d  = data_out;
                    state_d = ST_DONE;
                end else begin
                    data_d = round_y;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
`ifdef HIGHT_CLR_ON_DONE_EN
                    data_d  = '0;
                    wk_d    = '0;
                    dout_d  = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any block in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rnd_q   <= '0;
            data_q  <= '0;
            wk_q    <= '0;
            dout_q  <= '0;
            ed_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            data_q  <= data_d;
            wk_q    <= wk_d;
            dout_q  <= dout_d;
            ed_q    <= ed_d;
            armed_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hight_round_core.sv
// Bench for hight_round_core: three instances (SK_LAT = 3, 1, 7), each fed by its own
// delayed subkey-generator model. Directed sequence with a scoreboard queue.
module tb_hight_round_core;

    localparam int NI = 3;
    localparam logic [127:0] KAT_KEY = 128'h00112233445566778899aabbccddeeff;
    localparam logic [63:0]  KAT_CT  = 64'h00f418aed94f03f2;

    function automatic int lat_of(input int g);
        return (g == 0) ? 3 : (g == 1) ? 1 : 7;
    endfunction

    // HIGHT delta constants from the 7-bit LFSR sequence, s0..s6 = 0,1,0,1,1,0,1.
    function automatic logic [7:0] delta(input int idx);
        logic [133:0] s;
        s = '0;
        s[6:0] = 7'b1011010;
        for (int i = 1; i < 128; i++) begin
            s[i+6] = s[i+2] ^ s[i-1];
        end
        return {1'b0, s[idx +: 7]};
    endfunction

    // Subkey SK_idx from the master key.
    function automatic logic [7:0] hight_sk(input logic [127:0] key, input int idx);
        int i;
        int j;
        int mi;
        i  = idx / 16;
        j  = idx % 16;
        mi = (j < 8) ? ((j - i) & 7) : (((j - 8 - i) & 7) + 8);
        return key[8*mi +: 8] + delta(idx);
    endfunction

    logic          clk;
    logic          reset_n;
    logic          ed;
    logic [63:0]   din;
    logic [127:0]  mk;
    logic [NI-1:0] in_valid_v;
    logic [NI-1:0] out_ready_v;
    logic [NI-1:0] in_ready_v;
    logic [NI-1:0] out_valid_v;
    logic [NI-1:0] sk_init_v;
    logic [NI-1:0] sk_ed_v;
    logic [NI-1:0] busy_v;
    logic [NI-1:0][63:0] dout_v;

    int n_assert;
    int n_fail;
    int n_accept;
    int n_sk_init;
    logic [63:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n) n_sk_init <= n_sk_init + $countones(sk_init_v);
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L = lat_of(g);
        logic [7:0] sk0, sk1, sk2, sk3;
        logic [7:0] sk_tab [128];
        int phase;
        int kr;
        int b;

        // Generator model: restarts on sk_init, first set valid SK_LAT cycles later.
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                phase <= 1000;
            end else if (sk_init_v[g]) begin
                phase <= 1;
                for (int i = 0; i < 128; i++) sk_tab[i] <= hight_sk(mk, i);
            end else if (phase < 1000) begin
                phase <= phase + 1;
            end
        end

        always_comb begin
            kr  = phase - int'(L);
            b   = 0;
            sk0 = 8'h00;
            sk1 = 8'h00;
            sk2 = 8'h00;
            sk3 = 8'h00;
            if (kr >= 0 && kr < 32) begin
                b   = sk_ed_v[g] ? 4 * kr : 4 * (31 - kr);
                sk0 = sk_tab[b];
                sk1 = sk_tab[b+1];
                sk2 = sk_tab[b+2];
                sk3 = sk_tab[b+3];
            end
        end

        hight_round_core #(.SK_LAT(L)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .ed        (ed),
            .din       (din),
            .mk        (mk),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .dout      (dout_v[g]),
            .sk_init   (sk_init_v[g]),
            .sk_ed     (sk_ed_v[g]),
            .sk0       (sk0),
            .sk1       (sk1),
            .sk2       (sk2),
            .sk3       (sk3),
            .busy      (busy_v[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One block on instance n; hold = cycles of out_ready low in DONE before the handshake.
    task automatic run_block(input int n, input logic e, input logic [63:0] d,
                             input logic [127:0] key, input bit known, input logic [63:0] exp,
                             input int hold, output logic [63:0] res);
        int w;
        int k;
        logic [63:0] want;
        @(negedge clk);
        ed  = e;
        din = d;
        mk  = key;
        in_valid_v[n] = 1'b1;
        w = 0;
        while (!in_ready_v[n] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 64'(in_ready_v[n]), 64'd1);
        if (known) exp_q.push_back(exp);
        n_accept++;
        @(posedge clk);
        #1;
        in_valid_v[n] = 1'b0;
        ed  = ~e;
        din = {$urandom(), $urandom()};
        mk  = {$urandom(), $urandom(), $urandom(), $urandom()};
        k = 1;
        @(negedge clk);
        while (!out_valid_v[n] && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 64'(k), 64'(lat_of(n) + 32));
        chk("sk_ed", 64'(sk_ed_v[n]), 64'(e));
        res = dout_v[n];
        if (known && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk("dout", dout_v[n], want);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid_v[n] = i[0];
            @(negedge clk);
            chk("hold_valid", 64'(out_valid_v[n]), 64'd1);
            chk("hold_dout", dout_v[n], res);
            chk("hold_in_ready", 64'(in_ready_v[n]), 64'd0);
        end
        in_valid_v[n]  = 1'b0;
        out_ready_v[n] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[n] = 1'b0;
        @(negedge clk);
        chk("post_valid", 64'(out_valid_v[n]), 64'd0);
        chk("post_busy", 64'(busy_v[n]), 64'd0);
`ifdef HIGHT_CLR_ON_DONE_EN
        chk("post_dout_clr", dout_v[n], 64'd0);
`else
        chk("post_dout_keep", dout_v[n], res);
`endif
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] ct;
        logic [63:0] pt;
        logic [127:0] key;
        n_assert    = 0;
        n_fail      = 0;
        n_accept    = 0;
        n_sk_init   = 0;
        reset_n     = 1'b0;
        ed          = 1'b0;
        din         = '0;
        mk          = '0;
        in_valid_v  = '0;
        out_ready_v = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready_v), 64'd0);
        chk("rst_out_valid", 64'(out_valid_v), 64'd0);
        chk("rst_dout", dout_v[0], 64'd0);
        chk("rst_sk_init", 64'(sk_init_v), 64'd0);
        chk("rst_sk_ed", 64'(sk_ed_v), 64'd0);
        chk("rst_busy", 64'(busy_v), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready_v), 64'(3'b111));

        // Known-answer tests, encrypt with 10 cycles of backpressure.
        run_block(0, 1'b1, 64'd0, KAT_KEY, 1'b1, KAT_CT, 10, r);
        run_block(0, 1'b0, KAT_CT, KAT_KEY, 1'b1, 64'd0, 0, r);

        // Random round trips.
        for (int i = 0; i < 100; i++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom()};
            run_block(0, 1'b1, pt, key, 1'b0, 64'd0, 0, ct);
            run_block(0, 1'b0, ct, key, 1'b1, pt, 0, r);
        end

        // Reset during round 15, then the KAT again.
        @(negedge clk);
        ed  = 1'b1;
        din = 64'd0;
        mk  = KAT_KEY;
        in_valid_v[0] = 1'b1;
        chk("mid_ready", 64'(in_ready_v[0]), 64'd1);
        n_accept++;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        repeat (lat_of(0) + 15) @(negedge clk);
        chk("mid_busy", 64'(busy_v[0]), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_v[0]), 64'd0);
        chk("abort_sk_ed", 64'(sk_ed_v[0]), 64'd0);
        chk("abort_dout", dout_v[0], 64'd0);
        chk("abort_in_ready", 64'(in_ready_v[0]), 64'd0);
        chk("abort_out_valid", 64'(out_valid_v[0]), 64'd0);
        chk("abort_sk_init", 64'(sk_init_v[0]), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_block(0, 1'b1, 64'd0, KAT_KEY, 1'b1, KAT_CT, 0, r);

        // Minimum and maximum generator latency.
        run_block(1, 1'b1, 64'd0, KAT_KEY, 1'b1, KAT_CT, 0, r);
        run_block(1, 1'b0, KAT_CT, KAT_KEY, 1'b1, 64'd0, 0, r);
        run_block(2, 1'b1, 64'd0, KAT_KEY, 1'b1, KAT_CT, 0, r);
        run_block(2, 1'b0, KAT_CT, KAT_KEY, 1'b1, 64'd0, 0, r);

        @(negedge clk);
        chk("sk_init_pulses", 64'(n_sk_init), 64'(n_accept));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
